fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline.
- Holds the program counter and computes PC+4, which feeds the next-PC select mux's add_result input.
- Takes the mux's instruction_address output back in as `next_pc`.
- Fetches through a ready-handshaked instruction-memory port and loads the IF/ID pipeline register.
- Handles hazard stalls, branch flushes and multi-cycle memory waits, and keeps a retired-fetch counter.

---
 rtl/fetch_stage.sv | 91 +++++++++
 tb/tb_fetch_stage.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage with PC register, ready-handshaked
// instruction-memory port, IF/ID pipeline register and retired-fetch counter.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [31:0] fetch_count,
    output logic        fetch_busy
);
    typedef enum logic [1:0] {IDLE, FETCH, WAIT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            cnt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Priority: flush over stall over hit; a stalled hit is dropped and re-read.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            state_d = FETCH;
        end else if (flush) begin
            pc_d    = next_pc;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            state_d = FETCH;
        end else if (stall) begin
            state_d = imem_ready ? FETCH : WAIT;
        end else if (imem_ready) begin
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = next_pc;
            cnt_d   = cnt_q + 32'd1;
            state_d = FETCH;
        end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            state_d = WAIT;
        end
    end

    assign imem_req    = state_q != IDLE;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign fetch_count = cnt_q;
    assign fetch_busy  = state_q == WAIT;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed tests for fetch_stage with a zero/multi-wait memory
// model returning addr ^ 32'hA5A5_0000.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] next_pc;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] imem_rdata;
    logic        imem_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] fetch_count;
    logic        fetch_busy;
    logic        follow = 1'b1;
    logic [31:0] np_fixed = 32'h0;
    int          total = 0;
    int          passed = 0;

    fetch_stage dut (
        .clk(clk), .reset(reset), .next_pc(next_pc), .stall(stall), .flush(flush),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .imem_req(imem_req),
        .imem_addr(imem_addr), .pc(pc), .pc_plus4(pc_plus4), .if_id_instr(if_id_instr),
        .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .fetch_count(fetch_count),
        .fetch_busy(fetch_busy)
    );

    always #5 clk = ~clk;
    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;
    assign next_pc = follow ? pc_plus4 : np_fixed;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        follow = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        #1;
        total++; if (pc !== 32'h0) $display("FAIL rst_pc got %h want 0", pc); else passed++;
        total++; if (if_id_instr !== 32'h0) $display("FAIL rst_instr got %h want 0", if_id_instr); else passed++;
        total++; if (if_id_pc4 !== 32'h0) $display("FAIL rst_pc4 got %h want 0", if_id_pc4); else passed++;
        total++; if (if_id_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", if_id_valid); else passed++;
        total++; if (fetch_count !== 32'h0) $display("FAIL rst_count got %h want 0", fetch_count); else passed++;
        total++; if (imem_req !== 1'b0 || fetch_busy !== 1'b0) $display("FAIL rst_req_busy got %b%b want 00", imem_req, fetch_busy); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        imem_ready = 1'b1;
        step();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL cold_first_req got req=%b addr=%h want 1/0", imem_req, imem_addr); else passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (if_id_instr !== (32'hA5A5_0000 | 32'(i * 4)) || if_id_valid !== 1'b1)
                $display("FAIL cold_instr%0d got %h/%b want %h/1", i, if_id_instr, if_id_valid, 32'hA5A5_0000 | 32'(i * 4)); else passed++;
        end
        total++; if (fetch_count !== 32'd3) $display("FAIL cold_count got %0d want 3", fetch_count); else passed++;
        total++; if (pc !== 32'hC) $display("FAIL cold_pc got %h want c", pc); else passed++;
    endtask

    task automatic test_wait_states();
        do_reset();
        imem_ready = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 2; w++) begin
                imem_ready = 1'b0;
                step();
                total++; if (fetch_busy !== 1'b1 || if_id_valid !== 1'b0 || imem_addr !== 32'(k * 4))
                    $display("FAIL wait_busy%0d_%0d got busy=%b valid=%b addr=%h want 1/0/%h", k, w, fetch_busy, if_id_valid, imem_addr, 32'(k * 4)); else passed++;
            end
            imem_ready = 1'b1;
            step();
            total++; if (if_id_instr !== (32'hA5A5_0000 | 32'(k * 4)) || if_id_valid !== 1'b1 || fetch_busy !== 1'b0)
                $display("FAIL wait_hit%0d got %h/%b/%b want %h/1/0", k, if_id_instr, if_id_valid, fetch_busy, 32'hA5A5_0000 | 32'(k * 4)); else passed++;
        end
        total++; if (fetch_count !== 32'd2) $display("FAIL wait_count got %0d want 2", fetch_count); else passed++;
    endtask

    task automatic test_stall_flush();
        do_reset();
        imem_ready = 1'b1;
        step();
        step();
        step();
        stall = 1'b1;
        for (int s = 0; s < 2; s++) begin
            step();
            total++; if (pc !== 32'h8 || if_id_instr !== 32'hA5A5_0004 || fetch_count !== 32'd2)
                $display("FAIL stall_hold%0d got pc=%h instr=%h cnt=%0d want 8/a5a50004/2", s, pc, if_id_instr, fetch_count); else passed++;
        end
        stall = 1'b0;
        step();
        total++; if (if_id_instr !== 32'hA5A5_0008 || fetch_count !== 32'd3 || pc !== 32'hC)
            $display("FAIL stall_release got instr=%h cnt=%0d pc=%h want a5a50008/3/c", if_id_instr, fetch_count, pc); else passed++;
        follow = 1'b0;
        np_fixed = 32'h40;
        flush = 1'b1;
        stall = 1'b1;
        step();
        flush = 1'b0;
        stall = 1'b0;
        total++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || fetch_count !== 32'd3)
            $display("FAIL flush_bubble got valid=%b instr=%h cnt=%0d want 0/0/3", if_id_valid, if_id_instr, fetch_count); else passed++;
        total++; if (if_id_pc4 !== 32'hC) $display("FAIL flush_pc4 got %h want c", if_id_pc4); else passed++;
        total++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) $display("FAIL flush_redirect got addr=%h req=%b want 40/1", imem_addr, imem_req); else passed++;
        follow = 1'b1;
        step();
        total++; if (if_id_instr !== 32'hA5A5_0040 || fetch_count !== 32'd4)
            $display("FAIL flush_next got instr=%h cnt=%0d want a5a50040/4", if_id_instr, fetch_count); else passed++;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        imem_ready = 1'b1;
        step();
        for (int i = 0; i < 4; i++) step();
        imem_ready = 1'b0;
        step();
        total++; if (fetch_busy !== 1'b1 || pc !== 32'h10) $display("FAIL midwait_setup got busy=%b pc=%h want 1/10", fetch_busy, pc); else passed++;
        #2;
        reset = 1'b1;
        #1;
        total++; if (pc !== 32'h0 || imem_req !== 1'b0 || fetch_count !== 32'h0 || fetch_busy !== 1'b0)
            $display("FAIL midwait_reset got pc=%h req=%b cnt=%0d busy=%b want 0/0/0/0", pc, imem_req, fetch_count, fetch_busy); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        follow = 1'b0;
        np_fixed = 32'hFFFF_FFFC;
        imem_ready = 1'b1;
        step();
        step();
        total++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) $display("FAIL wrap_pc got pc=%h pc4=%h want fffffffc/0", pc, pc_plus4); else passed++;
        np_fixed = 32'h0;
        step();
        total++; if (if_id_pc4 !== 32'h0 || if_id_instr !== 32'h5A5A_FFFC || pc !== 32'h0)
            $display("FAIL wrap_load got pc4=%h instr=%h pc=%h want 0/5a5afffc/0", if_id_pc4, if_id_instr, pc); else passed++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wait_states();
        test_stall_flush();
        test_reset_mid_wait();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
